// File: rtl/cnn_fixed_pkg.sv
// Fixed-point formats, saturation helper and accumulator FSM states shared by
// the CNN conv datapath.
package cnn_fixed_pkg;

  localparam int DEF_WIDTH     = 14;
  localparam int DEF_FRAC_BITS = 7;
  localparam int SAT_MAX       = (1 << (DEF_WIDTH - 1)) - 1;
  localparam int SAT_MIN       = -(1 << (DEF_WIDTH - 1));
  localparam int RELU6_MAX     = 6 << DEF_FRAC_BITS;

  typedef enum logic [0:0] {
    ACC_IDLE,
    ACC_RUN
  } acc_state_e;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/pipelined_adder_tree.sv
// Registered binary reduction of N signed lanes (zero-padded to a power of two),
// with a sideband delay line that stays aligned with the sum.
module pipelined_adder_tree #(
  parameter int N    = 32,
  parameter int IN_W = 14,
  parameter int SB_W = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N*IN_W-1:0]                data,
  input  logic [SB_W-1:0]                  sb_in,
  output logic signed [IN_W+$clog2(N)-1:0] sum,
  output logic [SB_W-1:0]                  sb_out
);

  localparam int STAGES = $clog2(N);
  localparam int PADDED = 1 << STAGES;
  localparam int DEPTH  = STAGES + 1;

  // Level 0 captures the inputs; level l holds PADDED>>l partial sums, one bit wider each level.
  for (genvar l = 0; l <= STAGES; l++) begin : g_lvl
    localparam int LW  = IN_W + l;
    localparam int CNT = PADDED >> l;

    logic [CNT*LW-1:0] v;
    logic [CNT*LW-1:0] v_nxt;

    if (l == 0) begin : g_in
      assign v_nxt = (CNT*LW)'(data);
    end else begin : g_add
      localparam int PW = LW - 1;
      always_comb begin
        for (int j = 0; j < CNT; j++) begin
          v_nxt[j*LW +: LW] = LW'($signed(g_lvl[l-1].v[2*j*PW +: PW]))
                            + LW'($signed(g_lvl[l-1].v[(2*j+1)*PW +: PW]));
        end
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) v <= '0;
      else      v <= v_nxt;
    end
  end

  assign sum = $signed(g_lvl[STAGES].v);

  logic [SB_W-1:0] sb_pipe [DEPTH];

  // NOTE: this delay line is reset, not left as plain storage, so a stale valid cannot emerge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) sb_pipe[i] <= '0;
    end else begin
      sb_pipe[0] <= sb_in;
      for (int i = 1; i < DEPTH; i++) sb_pipe[i] <= sb_pipe[i-1];
    end
  end

  assign sb_out = sb_pipe[DEPTH-1];

endmodule

// File: rtl/product_accumulator.sv
// Reduces each beat of multiplier products, accumulates over a window, adds bias and emits
// one saturated result per window. Define RELU6_EN to clamp the result to [0, 6.0].
module product_accumulator
  import cnn_fixed_pkg::*;
#(
  parameter int NUM_INSTANCES = 32,
  parameter int WIDTH         = DEF_WIDTH,
  parameter int FRAC_BITS     = DEF_FRAC_BITS,
  parameter int MAX_BEATS     = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_INSTANCES*WIDTH-1:0]     products,
  input  logic                               in_valid,
  input  logic                               in_last,
  input  logic signed [WIDTH-1:0]            bias,
  output logic                               out_valid,
  output logic signed [WIDTH-1:0]            result,
  output logic [$clog2(MAX_BEATS):0]         beat_count,
  output logic                               overrun
);

  localparam int STAGES = $clog2(NUM_INSTANCES);
  localparam int SUM_W  = WIDTH + STAGES;
  localparam int BC_W   = $clog2(MAX_BEATS) + 1;
  localparam int ACC_W  = WIDTH + STAGES + $clog2(MAX_BEATS) + 1;

`ifdef RELU6_EN
  localparam bit RELU6 = 1'b1;
`else
  localparam bit RELU6 = 1'b0;
`endif
  localparam logic signed [WIDTH-1:0] RELU6_LIM = WIDTH'(6 << FRAC_BITS);

  logic signed [SUM_W-1:0] t_sum;
  logic [WIDTH+1:0]        t_sb;
  logic                    t_valid;
  logic                    t_last;
  logic signed [WIDTH-1:0] t_bias;

  // valid/last/bias ride the tree's delay line so they arrive with their beat's sum.
  pipelined_adder_tree #(
    .N    (NUM_INSTANCES),
    .IN_W (WIDTH),
    .SB_W (WIDTH + 2)
  ) u_tree (
    .clk    (clk),
    .rst    (rst),
    .data   (products),
    .sb_in  ({in_valid, in_last, bias}),
    .sum    (t_sum),
    .sb_out (t_sb)
  );

  assign {t_valid, t_last, t_bias} = t_sb;

  acc_state_e              state, state_nxt;
  logic signed [ACC_W-1:0] acc, acc_nxt, acc_base, total;
  logic [BC_W-1:0]         beat_count_nxt, beat_inc;
  logic                    overrun_nxt, emit;
  logic signed [WIDTH-1:0] result_nxt;

  // NOTE: every variable gets a default before any branch, so no latch is inferred.
  always_comb begin
    state_nxt      = state;
    acc_nxt        = acc;
    beat_count_nxt = beat_count;
    overrun_nxt    = overrun;
    emit           = 1'b0;
    acc_base       = (state == ACC_RUN) ? acc : '0;
    beat_inc       = (beat_count == '1) ? beat_count : beat_count + 1'b1;
    total          = acc_base + ACC_W'(t_sum) + ACC_W'(t_bias);
    result_nxt     = WIDTH'(saturate(64'(total), WIDTH));

    if (RELU6) begin
      if (result_nxt < 0)              result_nxt = '0;
      else if (result_nxt > RELU6_LIM) result_nxt = RELU6_LIM;
    end

    if (t_valid) begin
      if (beat_inc > BC_W'(MAX_BEATS)) overrun_nxt = 1'b1;
      if (t_last) begin
        emit           = 1'b1;
        state_nxt      = ACC_IDLE;
        acc_nxt        = '0;
        beat_count_nxt = '0;
      end else begin
        state_nxt      = ACC_RUN;
        acc_nxt        = acc_base + ACC_W'(t_sum);
        beat_count_nxt = beat_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ACC_IDLE;
      acc        <= '0;
      beat_count <= '0;
      overrun    <= 1'b0;
      out_valid  <= 1'b0;
      result     <= '0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      beat_count <= beat_count_nxt;
      overrun    <= overrun_nxt;
      out_valid  <= emit;
      if (emit) result <= result_nxt;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized scoreboard bench for product_accumulator; expected window results come from
// plain integer sums of all lanes and beats plus bias, then clamping.
`timescale 1ns/1ps
module tb_product_accumulator;

  localparam int N    = 32;
  localparam int W    = 14;
  localparam int F    = 7;
  localparam int MB   = 64;
  localparam int BC_W = $clog2(MB) + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [N*W-1:0]      products = '0;
  logic                in_valid = 1'b0;
  logic                in_last = 1'b0;
  logic signed [W-1:0] bias = '0;
  logic                out_valid;
  logic signed [W-1:0] result;
  logic [BC_W-1:0]     beat_count;
  logic                overrun;

  product_accumulator #(
    .NUM_INSTANCES (N),
    .WIDTH         (W),
    .FRAC_BITS     (F),
    .MAX_BEATS     (MB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .products   (products),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .bias       (bias),
    .out_valid  (out_valid),
    .result     (result),
    .beat_count (beat_count),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int value;
    int cyc;
  } exp_t;

  exp_t   sb[$];
  int     n_vec = 0;
  int     n_err = 0;
  int     cyc = 0;
  int     last_result = 0;
  longint win_sum = 0;
  int     lanes[N];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint actual, input longint expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: saturate to signed W bits, then optional ReLU6 clamp to [0, 6.0].
  function automatic int ref_result(input longint s);
    longint hi = (longint'(1) << (W - 1)) - 1;
    longint lo = -(longint'(1) << (W - 1));
    if (s > hi) s = hi;
    if (s < lo) s = lo;
`ifdef RELU6_EN
    if (s < 0) s = 0;
    if (s > 6 * (1 << F)) s = 6 * (1 << F);
`endif
    return int'(s);
  endfunction

  // Monitor: every out_valid pulse must match the oldest pending window, on its expected cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("result", $signed(result), e.value);
        check("emit_cycle", cyc, e.cyc);
        last_result = e.value;
      end
    end
  end

  task automatic set_all(input int v);
    for (int i = 0; i < N; i++) lanes[i] = v;
  endtask

  task automatic set_lane0(input int v);
    for (int i = 0; i < N; i++) lanes[i] = 0;
    lanes[0] = v;
  endtask

  task automatic rand_lanes(input bit big);
    for (int i = 0; i < N; i++)
      lanes[i] = big ? int'($urandom_range(0, 16383)) - 8192 : int'($urandom_range(0, 64)) - 32;
  endtask

  // One beat presented for one posedge; a last beat predicts the window result
  // for the 6th posedge after the sampling edge.
  task automatic send_beat(input bit last, input int b);
    longint s = 0;
    exp_t   e;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      products[i*W +: W] = W'(lanes[i]);
      s += lanes[i];
    end
    in_valid = 1'b1;
    in_last  = last;
    bias     = W'(b);
    win_sum += s;
    if (last) begin
      e.value = ref_result(win_sum + b);
      e.cyc   = cyc + 7;
      sb.push_back(e);
      win_sum = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int i = 0;
    idle(1);
    while (sb.size() != 0 && i < 40) begin
      @(negedge clk);
      i++;
    end
    if (sb.size() != 0) begin
      check({tag, "_drain_timeout_pending"}, sb.size(), 0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
    check({tag, "_out_valid_idle"}, out_valid, 0);
    check({tag, "_result_hold"}, $signed(result), last_result);
    check({tag, "_beat_count_idle"}, beat_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    bit big;

    repeat (3) @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_beat_count", beat_count, 0);
    check("reset_overrun", overrun, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    set_all(128);
    send_beat(1'b1, 0);
    drain("single_beat_ones");

    set_all(128);
    send_beat(1'b0, 0);
    send_beat(1'b1, 0);
    drain("two_beat_saturate");

    set_all(-128);
    send_beat(1'b1, 64);
    drain("neg_ones_bias");

    set_lane0(1);
    for (int k = 0; k < 4; k++) begin
      send_beat(k == 3, 0);
      if (k < 3) idle(2);
    end
    drain("gapped_beats");

    rand_lanes(1'b0);
    for (int k = 0; k < 3; k++) send_beat(1'b0, 0);
    idle(10);
    check("mid_window_beat_count", beat_count, 3);
    @(negedge clk);
    rst = 1'b0;
    win_sum = 0;
    last_result = 0;
    repeat (2) @(negedge clk);
    check("abort_result", result, 0);
    check("abort_beat_count", beat_count, 0);
    rst = 1'b1;
    idle(2);
    set_lane0(10);
    send_beat(1'b1, 0);
    drain("after_abort");

    set_lane0(5);
    send_beat(1'b1, 0);
    set_lane0(7);
    send_beat(1'b1, 0);
    drain("back_to_back");

    for (int w = 0; w < 25; w++) begin
      nb  = int'($urandom_range(1, 6));
      big = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < nb; b++) begin
        rand_lanes(big);
        send_beat(b == nb - 1, int'($urandom_range(0, 16383)) - 8192);
        if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
      end
    end
    drain("random_windows");
    check("random_overrun", overrun, 0);

    for (int b = 0; b < MB; b++) begin
      rand_lanes(1'b0);
      send_beat(b == MB - 1, 17);
    end
    drain("max_window");
    check("max_window_overrun", overrun, 0);

    for (int b = 0; b < MB + 1; b++) begin
      rand_lanes(1'b0);
      send_beat(b == MB, -5);
    end
    drain("overlong_window");
    check("overlong_overrun", overrun, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
